parity_serial_tx: RTL and testbench

Serialiser stage directly downstream of the 8-bit parity generator. Accepts a byte plus its even-parity bit over a valid/ready handshake. Transmits one framed word LSB-first on a single line: start bit, 8 data bits, parity bit, stop bit. Each bit is held for a programmable number of clock cycles.

---
 rtl/parity_serial_tx.sv | 140 ++++++++++++++
 tb/tb_parity_serial_tx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/parity_serial_tx.sv
// Serialiser for a byte plus parity: start, 8 data bits LSB-first, parity, stop.
// Each bit is held for CLKS_PER_BIT cycles; one word is accepted per frame in idle.
module parity_serial_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          ODD_PARITY   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       par_in,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  localparam logic [15:0] ClkMax = 16'(CLKS_PER_BIT - 1);

  state_e      state_q, state_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  sh_q, sh_d;
  logic        par_q, par_d;
  logic        bit_end;

  assign bit_end = (clk_cnt_q == ClkMax);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      clk_cnt_q <= 16'd0;
      bit_cnt_q <= 3'd0;
      sh_q      <= 8'd0;
      par_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      par_q     <= par_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    par_d     = par_q;

    unique case (state_q)
      StIdle: begin
        clk_cnt_d = 16'd0;
        bit_cnt_d = 3'd0;
        // Handshake only here; din_valid elsewhere is ignored, nothing queued.
        if (din_valid) begin
          sh_d    = din;
          par_d   = par_in ^ ODD_PARITY;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          clk_cnt_d = 16'd0;
          bit_cnt_d = 3'd0;
          state_d   = StData;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      StData: begin
        if (bit_end) begin
          clk_cnt_d = 16'd0;
          sh_d      = {1'b0, sh_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
            state_d   = StParity;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      StParity: begin
        if (bit_end) begin
          clk_cnt_d = 16'd0;
          state_d   = StStop;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      StStop: begin
        if (bit_end) begin
          clk_cnt_d = 16'd0;
          state_d   = StIdle;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d   = StIdle;
        clk_cnt_d = 16'd0;
        bit_cnt_d = 3'd0;
      end
    endcase
  end

  // Outputs decode registered state only, so no input reaches an output combinationally.
  always_comb begin
    tx         = 1'b1;
    busy       = 1'b1;
    din_ready  = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy      = 1'b0;
        din_ready = 1'b1;
      end
      StStart:  tx = 1'b0;
      StData:   tx = sh_q[0];
      StParity: tx = par_q;
      StStop:   frame_done = bit_end;
      default: begin
        busy      = 1'b0;
        din_ready = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_parity_serial_tx.sv
// Bench for parity_serial_tx: three instances (even C=4, odd C=4, even C=1) share stimulus
// and are checked every cycle against a frame-offset reference model.
module tb_parity_serial_tx;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       par_in;
  logic       din_valid;
  logic [2:0] rdy, txo, bsy, done;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int done_cnt = 0;
  int hs_t[$];

  // Reference model: a frame is a list of 11 bits; offset since the handshake edge picks the bit.
  int unsigned cpb[3]  = '{4, 4, 1};
  bit          oddp[3] = '{1'b0, 1'b1, 1'b0};
  bit          active[3];
  int          off[3];
  logic [10:0] bits[3];

  parity_serial_tx #(.CLKS_PER_BIT(4), .ODD_PARITY(1'b0)) dut_even (
    .clk(clk), .rst(rst), .din(din), .par_in(par_in), .din_valid(din_valid),
    .din_ready(rdy[0]), .tx(txo[0]), .busy(bsy[0]), .frame_done(done[0])
  );

  parity_serial_tx #(.CLKS_PER_BIT(4), .ODD_PARITY(1'b1)) dut_odd (
    .clk(clk), .rst(rst), .din(din), .par_in(par_in), .din_valid(din_valid),
    .din_ready(rdy[1]), .tx(txo[1]), .busy(bsy[1]), .frame_done(done[1])
  );

  parity_serial_tx #(.CLKS_PER_BIT(1), .ODD_PARITY(1'b0)) dut_fast (
    .clk(clk), .rst(rst), .din(din), .par_in(par_in), .din_valid(din_valid),
    .din_ready(rdy[2]), .tx(txo[2]), .busy(bsy[2]), .frame_done(done[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int k, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s dut%0d cyc=%0d observed=%b expected=%b", tag, k, cyc, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  // One clock: advance model on the rising edge, compare all outputs on the falling edge.
  task automatic step();
    bit hs;
    int flen;
    logic e_tx, e_bsy, e_rdy, e_done;
    hs = rdy[0] && din_valid && !rst;
    @(posedge clk);
    cyc++;
    if (hs) hs_t.push_back(cyc);
    for (int k = 0; k < 3; k++) begin
      flen = 11 * int'(cpb[k]);
      if (rst) begin
        active[k] = 1'b0;
      end else if (active[k]) begin
        off[k]++;
        if (off[k] > flen) active[k] = 1'b0;
      end else if (din_valid) begin
        active[k] = 1'b1;
        off[k]    = 1;
        bits[k]   = {1'b1, par_in ^ oddp[k], din, 1'b0};
      end
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      flen = 11 * int'(cpb[k]);
      if (active[k]) begin
        e_tx   = bits[k][(off[k] - 1) / int'(cpb[k])];
        e_bsy  = 1'b1;
        e_rdy  = 1'b0;
        e_done = (off[k] == flen);
      end else begin
        e_tx   = 1'b1;
        e_bsy  = 1'b0;
        e_rdy  = 1'b1;
        e_done = 1'b0;
      end
      chk("tx", k, txo[k], e_tx);
      chk("busy", k, bsy[k], e_bsy);
      chk("din_ready", k, rdy[k], e_rdy);
      chk("frame_done", k, done[k], e_done);
    end
    if (done[0]) done_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int base;
    rst       = 1'b1;
    din       = 8'h00;
    par_in    = 1'b0;
    din_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      active[k] = 1'b0;
      off[k]    = 0;
      bits[k]   = 11'h7ff;
    end

    // Reset held three cycles, then idle with no traffic.
    run(3);
    rst = 1'b0;
    run(5);

    // Even frame 0xA5.
    done_cnt  = 0;
    base      = hs_t.size();
    din       = 8'hA5;
    par_in    = 1'b0;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    run(50);
    chk_int("a5_frame_done_count", done_cnt, 1);
    chk_int("a5_handshakes", hs_t.size() - base, 1);

    // Odd-parity instance: parity slot must be 0 for 0x01 with par_in=1.
    din       = 8'h01;
    par_in    = 1'b1;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    run(50);

    // Back-to-back with din_valid held high.
    base      = hs_t.size();
    din       = 8'h3C;
    par_in    = 1'b0;
    din_valid = 1'b1;
    step();
    din = 8'hFF;
    run(45);
    din_valid = 1'b0;
    run(50);
    chk_int("b2b_handshakes", hs_t.size() - base, 2);
    if (hs_t.size() - base >= 2) chk_int("b2b_gap", hs_t[base + 1] - hs_t[base], 45);

    // Inputs toggle every cycle after the handshake.
    din       = 8'h96;
    par_in    = 1'b0;
    din_valid = 1'b1;
    step();
    for (int i = 0; i < 60; i++) begin
      din       = ~din;
      par_in    = ~par_in;
      din_valid = ~din_valid;
      step();
    end
    din_valid = 1'b0;
    run(50);

    // Reset during data bit 3 of the C=4 instance, then a fresh frame.
    din       = 8'($urandom);
    par_in    = ^din;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int i = 0; i < 40 && !(active[0] && off[0] == 17); i++) step();
    chk("bit3_busy", 0, bsy[0], 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("post_reset_tx", 0, txo[0], 1'b1);
    chk("post_reset_ready", 0, rdy[0], 1'b1);
    din       = 8'($urandom);
    par_in    = ^din;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    run(50);

    // Random traffic, including wrong parity and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      din       = 8'($urandom);
      par_in    = ($urandom_range(0, 3) == 0) ? ~(^din) : ^din;
      din_valid = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 199) == 0);
      step();
    end
    rst       = 1'b0;
    din_valid = 1'b0;
    run(50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
